// File: rtl/cle_key_pkg.sv
// Shared types and address helpers for the CLE040 key reader.
// The key window sits at BA13=0, BA12=1 with the challenge nibble on BA7..BA4.
package cle_key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      SETUP,
      STROBE,
      RECOV,
      FIN
   } cle_rd_state_t;

   localparam logic KEY_WIN_BA13 = 1'b0;
   localparam logic KEY_WIN_BA12 = 1'b1;

   function automatic logic [13:0] key_addr(input logic [3:0] nibble);
      return {KEY_WIN_BA13, KEY_WIN_BA12, 4'b0000, nibble, 4'b0000};
   endfunction

endpackage

// File: rtl/cle_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module cle_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/cle_key_reader.sv
// Host-side initiator for the CLE040 serial key responder: runs SEQ_LEN read strobes and compares the reply.
// Optional macro CLE_KEY_GNT_TIMEOUT_EN adds an err output and a bus-grant wait timeout.
module cle_key_reader
   import cle_key_pkg::*;
#(
   parameter int SEQ_LEN    = 8,
   parameter int STROBE_CYC = 3,
   parameter int RECOV_CYC  = 2,
   parameter int CNT_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [4*SEQ_LEN-1:0] challenge,
   input  logic [SEQ_LEN-1:0]   expected,
   output logic                 busy,
   output logic                 done,
   output logic [SEQ_LEN-1:0]   response,
   output logic                 match,
   output logic                 bus_req,
   input  logic                 bus_gnt,
   output logic [13:0]          ba,
   output logic                 br_w,
   output logic                 sser_n,
`ifdef CLE_KEY_GNT_TIMEOUT_EN
   output logic                 err,
`endif
   input  logic                 sdrd
);

   cle_rd_state_t        state_reg;
   logic [CNT_W-1:0]     cycle_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [4*SEQ_LEN-1:0] challenge_reg;
   logic [SEQ_LEN-1:0]   expected_reg;
   logic [SEQ_LEN-1:0]   response_reg;
   logic                 gnt_lost_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 match_reg;
   logic                 bus_req_reg;
   logic [13:0]          ba_reg;
   logic                 br_w_reg;
   logic                 sser_n_reg;
`ifdef CLE_KEY_GNT_TIMEOUT_EN
   logic [11:0]          wait_cnt_reg;
   logic                 err_reg;
`endif

   logic                 sdrd_sync;
   logic [CNT_W-1:0]     cycle_inc;
   logic [3:0]           nib [2**CNT_W];

   cle_sync2 u_sdrd_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sdrd),
      .q     (sdrd_sync)
   );

   // Full-depth nibble table so the cycle counter indexes it without width games.
   generate
      for (genvar gi = 0; gi < 2**CNT_W; gi++) begin : g_nib
         if (gi < SEQ_LEN) begin : g_used
            assign nib[gi] = challenge_reg[4*gi +: 4];
         end else begin : g_pad
            assign nib[gi] = 4'h0;
         end
      end
   endgenerate

   assign cycle_inc = cycle_reg + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cycle_reg     <= '0;
         cnt_reg       <= '0;
         challenge_reg <= '0;
         expected_reg  <= '0;
         response_reg  <= '0;
         gnt_lost_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         match_reg     <= 1'b0;
         bus_req_reg   <= 1'b0;
         ba_reg        <= '0;
         br_w_reg      <= 1'b1;
         sser_n_reg    <= 1'b1;
`ifdef CLE_KEY_GNT_TIMEOUT_EN
         wait_cnt_reg  <= '0;
         err_reg       <= 1'b0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  challenge_reg <= challenge;
                  expected_reg  <= expected;
                  response_reg  <= '0;
                  match_reg     <= 1'b0;
                  cycle_reg     <= '0;
                  cnt_reg       <= '0;
                  gnt_lost_reg  <= 1'b0;
                  busy_reg      <= 1'b1;
                  bus_req_reg   <= 1'b1;
                  state_reg     <= REQ;
`ifdef CLE_KEY_GNT_TIMEOUT_EN
                  wait_cnt_reg  <= '0;
                  err_reg       <= 1'b0;
`endif
               end
            end
            REQ: begin
               gnt_lost_reg <= 1'b0;
               if (bus_gnt) begin
                  ba_reg    <= key_addr(nib[cycle_reg]);
                  br_w_reg  <= 1'b1;
                  state_reg <= SETUP;
               end
`ifdef CLE_KEY_GNT_TIMEOUT_EN
               else if (wait_cnt_reg == 12'd4094) begin
                  done_reg    <= 1'b1;
                  match_reg   <= 1'b0;
                  err_reg     <= 1'b1;
                  bus_req_reg <= 1'b0;
                  ba_reg      <= '0;
                  busy_reg    <= 1'b0;
                  state_reg   <= FIN;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 12'd1;
               end
`endif
            end
            SETUP: begin
               if (!bus_gnt) gnt_lost_reg <= 1'b1;
               sser_n_reg <= 1'b0;
               cnt_reg    <= '0;
               state_reg  <= STROBE;
            end
            STROBE: begin
               if (!bus_gnt) gnt_lost_reg <= 1'b1;
               if (cnt_reg == CNT_W'(STROBE_CYC - 1)) begin
                  // response was cleared at start, so OR-ing sets exactly bit[cycle]
                  response_reg <= response_reg | (SEQ_LEN'(sdrd_sync) << cycle_reg);
                  sser_n_reg   <= 1'b1;
                  cnt_reg      <= '0;
                  state_reg    <= RECOV;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            RECOV: begin
               if (cnt_reg == CNT_W'(RECOV_CYC - 1)) begin
                  cnt_reg <= '0;
                  if (cycle_reg == CNT_W'(SEQ_LEN - 1)) begin
                     done_reg    <= 1'b1;
                     match_reg   <= (response_reg == expected_reg);
                     bus_req_reg <= 1'b0;
                     ba_reg      <= '0;
                     busy_reg    <= 1'b0;
                     state_reg   <= FIN;
                  end else begin
                     cycle_reg <= cycle_inc;
                     // A grant dropped anywhere in this cycle forces re-arbitration first.
                     if (gnt_lost_reg || !bus_gnt) begin
                        state_reg <= REQ;
`ifdef CLE_KEY_GNT_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                     end else begin
                        ba_reg    <= key_addr(nib[cycle_inc]);
                        state_reg <= SETUP;
                     end
                  end
               end else begin
                  if (!bus_gnt) gnt_lost_reg <= 1'b1;
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            FIN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign response = response_reg;
   assign match    = match_reg;
   assign bus_req  = bus_req_reg;
   assign ba       = ba_reg;
   assign br_w     = br_w_reg;
   assign sser_n   = sser_n_reg;
`ifdef CLE_KEY_GNT_TIMEOUT_EN
   assign err      = err_reg;
`endif

endmodule

// File: doc/cle_key_reader.md
Name: cle_key_reader

Overview:
- Host-side initiator for the CLE040 serial key/ID responder in the 93xx address decode.
- Runs a programmed sequence of bus read cycles into the key window: BA13=0, BA12=1, BR_W=1, SSER asserted low, with a challenge nibble on BA7..BA4.
- Samples the responder's SDRD data line on each cycle, assembles the bits into a response word and compares it against an expected value.
- Sits between the CPU-visible control registers and the backplane bus arbiter.

Parameters:
- SEQ_LEN, 8, number of read cycles (response bits) per transaction; range 1..16
- STROBE_CYC, 3, clocks SSER stays low per cycle; SDRD is sampled on the last of them; minimum 1
- RECOV_CYC, 2, clocks with SSER high between cycles; minimum 1
- CNT_W, 4, width of the cycle and strobe counters; must satisfy 2^CNT_W > max(SEQ_LEN, STROBE_CYC, RECOV_CYC)

Ports:
- clk  in  1  system clock; all logic rises on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-clock pulse that begins a transaction; ignored while busy=1
- challenge  in  4*SEQ_LEN  nibble i (bits 4i+3..4i) drives BA7..BA4 on cycle i; sampled at start
- expected  in  SEQ_LEN  expected response; sampled at start
- busy  out  1  high from the clock after an accepted start until done
- done  out  1  one-clock pulse when the transaction ends
- response  out  SEQ_LEN  bit i = SDRD sampled on cycle i; held until the next accepted start
- match  out  1  response==expected; valid from done until the next accepted start
- bus_req  out  1  bus request to the arbiter
- bus_gnt  in  1  bus grant from the arbiter
- ba  out  14  address BA13..BA0
- br_w  out  1  read/write; 1 = read
- sser_n  out  1  key select, active low
- sdrd  in  1  serial data from the responder; synchronised internally through 2 flops

Behaviour:
- Reset values (asynchronous, on rst_n=0): state=IDLE; busy=0, done=0, match=0, response=0, bus_req=0, ba=0, br_w=1, sser_n=1; all counters 0.
- Every bus output is registered.
- States: IDLE, REQ, SETUP, STROBE, RECOV, FIN.
- IDLE: on start, latch challenge and expected, clear response, cycle counter := 0, go to REQ. busy rises on the next clock.
- REQ: bus_req=1. Move to SETUP on the clock where bus_gnt=1.
- SETUP (1 clock): ba = {2'b01, 4'b0000, nibble[cycle], 4'b0000}, br_w=1, sser_n=1. Go to STROBE.
- STROBE: sser_n=0 for STROBE_CYC clocks; ba is held stable.
  - On the last STROBE clock, shift the synchronised sdrd into response[cycle].
  - The 2-flop synchroniser adds 2 clocks of latency, so the responder must hold SDRD for at least STROBE_CYC clocks.
- RECOV: sser_n=1 for RECOV_CYC clocks; ba is held.
  - If cycle==SEQ_LEN-1, go to FIN.
  - Otherwise cycle++ and go to SETUP. The bus is not released between cycles.
- FIN (1 clock): done=1, match=(response==expected), bus_req=0, ba=0, busy falls. Go to IDLE.
- Grant loss: if bus_gnt drops during SETUP, STROBE or RECOV:
  - finish the current STROBE/RECOV (the responder state machine must see whole cycles), then return to REQ;
  - keep the cycle counter; resume at the next cycle.
- start coinciding with done: ignored; a new start is accepted only in IDLE.
- sser_n is never low unless bus_gnt was high at SETUP entry.
- SEQ_LEN=1: exactly one cycle, then FIN.
- Reset mid-transaction: immediate return to reset values; sser_n goes high asynchronously. The responder resynchronises on its own.

Optional Feature:
- Macro: CLE_KEY_GNT_TIMEOUT_EN.
- When defined:
  - adds output err (1 bit, reset 0) and a 12-bit wait counter;
  - if REQ waits 4095 clocks without bus_gnt, go to FIN with done=1, match=0, err=1;
  - err clears on the next accepted start.
- When undefined: REQ waits indefinitely; no err port.

Decomposition:
- Package cle_key_pkg holds:
  - state enum cle_rd_state_t;
  - localparams KEY_WIN_BA13=0, KEY_WIN_BA12=1;
  - the ba-construction function key_addr(nibble).
- One sub-module, cle_sync2 (2-flop synchroniser, async active-low reset), instantiated for sdrd.

Test Plan:
- Reset: rst_n=0 mid-STROBE -> sser_n=1 and bus_req=0 the same cycle; all outputs at reset values.
- Nominal: SEQ_LEN=8, challenge=32'h1234_5678, responder model returns 8'hA5, expected=8'hA5, gnt always 1 -> 8 strobes with ba[7:4]=8,7,6,5,4,3,2,1 in cycle order; response=8'hA5; match=1; done exactly 1 clock.
- Mismatch: same stimulus with expected=8'hA4 -> response=8'hA5, match=0.
- Grant loss: drop bus_gnt during cycle 3 STROBE for 10 clocks -> cycle 3 strobe completes at full length; bus_req stays high; resume at cycle 4; 8 strobes total.
- Start during busy: pulse start at cycle 2 -> ignored; latched challenge unchanged.
- Timeout (CLE_KEY_GNT_TIMEOUT_EN defined): bus_gnt held 0 -> done and err at clock 4095 of REQ; sser_n never asserted.
